// File: rtl/stream_filter_pkg.sv
// Shared arithmetic helpers for the stream-filter datapath blocks.
// Widths are passed as arguments; operands are carried in 64-bit signed containers.
package stream_filter_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Full signed product; callers sign-extend operands and truncate the result to their width.
  function automatic logic signed [63:0] smul(input logic signed [63:0] a,
                                              input logic signed [63:0] b);
    return a * b;
  endfunction

  function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v,
                                                   input int shift);
    logic signed [63:0] r;
    r = v;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    return r >>> shift;
  endfunction

  function automatic logic signed [63:0] rnd_sat_val(input logic signed [63:0] v,
                                                     input int shift, input int out_w);
    logic signed [63:0] r, hi, lo;
    r  = rnd_shift(v, shift);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  function automatic logic rnd_sat_clip(input logic signed [63:0] v,
                                        input int shift, input int out_w);
    logic signed [63:0] r, hi, lo;
    r  = rnd_shift(v, shift);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (r > hi) || (r < lo);
  endfunction

endpackage

// File: rtl/multiply_add_chain_fir_tap.sv
// One systolic FIR tap: 4 acc registers and 3 image registers give one sample of skew per tap.
// flush clears every valid bit in the tap on the same edge it is sampled.
module fir_tap
  import stream_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int ACC_WIDTH = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [KER_WIDTH-1:0] ker,
  input  logic [IMG_WIDTH-1:0] img_i,
  input  logic                 img_val_i,
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic                 acc_val_i,
  output logic [IMG_WIDTH-1:0] img_o,
  output logic                 img_val_o,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 acc_val_o
);

  localparam int PW = IMG_WIDTH + KER_WIDTH;

  logic [IMG_WIDTH-1:0] img1_q, img1_d, img2_q, img2_d, img3_q, img3_d;
  logic                 iv1_q, iv1_d, iv2_q, iv2_d, iv3_q, iv3_d;
  logic [ACC_WIDTH-1:0] acc1_q, acc1_d, acc2_q, acc2_d, sum_q, sum_d, acc4_q, acc4_d;
  logic                 av1_q, av1_d, av2_q, av2_d, av3_q, av3_d, av4_q, av4_d;
  logic [PW-1:0]        prod_q, prod_d;

  always_comb begin
    img1_d = img_i;
    img2_d = img1_q;
    img3_d = img2_q;
    iv1_d  = img_val_i & ~flush;
    iv2_d  = iv1_q & ~flush;
    iv3_d  = iv2_q & ~flush;
    // A window stays valid only while every sample it has consumed was valid.
    acc1_d = acc_i;
    av1_d  = acc_val_i & img_val_i & ~flush;
    prod_d = PW'(smul(64'($signed(img1_q)), 64'($signed(ker))));
    acc2_d = acc1_q;
    av2_d  = av1_q & ~flush;
    sum_d  = $signed(acc2_q) + ACC_WIDTH'($signed(prod_q));
    av3_d  = av2_q & ~flush;
    acc4_d = sum_q;
    av4_d  = av3_q & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img1_q <= '0; img2_q <= '0; img3_q <= '0;
      iv1_q  <= 1'b0; iv2_q <= 1'b0; iv3_q <= 1'b0;
      acc1_q <= '0; acc2_q <= '0; sum_q <= '0; acc4_q <= '0;
      av1_q  <= 1'b0; av2_q <= 1'b0; av3_q <= 1'b0; av4_q <= 1'b0;
      prod_q <= '0;
    end else begin
      img1_q <= img1_d; img2_q <= img2_d; img3_q <= img3_d;
      iv1_q  <= iv1_d; iv2_q <= iv2_d; iv3_q <= iv3_d;
      acc1_q <= acc1_d; acc2_q <= acc2_d; sum_q <= sum_d; acc4_q <= acc4_d;
      av1_q  <= av1_d; av2_q <= av2_d; av3_q <= av3_d; av4_q <= av4_d;
      prod_q <= prod_d;
    end
  end

  assign img_o     = img3_q;
  assign img_val_o = iv3_q;
  assign acc_o     = acc4_q;
  assign acc_val_o = av4_q;

endmodule

// File: rtl/multiply_add_chain.sv
// Systolic FIR engine: double-buffered kernel with atomic commit, TAPS chained taps,
// round/shift/saturate output stage. Latency launch->result 4*TAPS+1, no backpressure.
module multiply_add_chain
  import stream_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int TAPS      = 4,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KER_WIDTH-1:0] cfg_ker,
  input  logic                 cfg_val,
  output logic                 cfg_done,
  input  logic [IMG_WIDTH-1:0] up_img,
  input  logic                 up_val,
  output logic [IMG_WIDTH-1:0] dn_img,
  output logic [OUT_WIDTH-1:0] dn_out,
  output logic                 dn_val,
  output logic                 dn_sat
);

  localparam int ACC_WIDTH = IMG_WIDTH + KER_WIDTH + clog2(TAPS);
  localparam int CNT_W     = (TAPS > 1) ? clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  logic [TAPS-1:0][KER_WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [CNT_W-1:0]               cfg_cnt_q, cfg_cnt_d;
  logic                           cfg_done_q, cfg_done_d, loaded_q, loaded_d, commit;
  logic [OUT_WIDTH-1:0]           dn_out_q, dn_out_d;
  logic                           dn_val_q, dn_val_d, dn_sat_q, dn_sat_d;

  logic [TAPS:0][IMG_WIDTH-1:0]   img_c;
  logic [TAPS:0]                  img_val_c;
  logic [TAPS:0][ACC_WIDTH-1:0]   acc_c;
  logic [TAPS:0]                  acc_val_c;
  logic                           img_val_unused;

  always_comb begin
    commit   = cfg_val && (cfg_cnt_q == CNT_LAST);
    shadow_d = shadow_q;
    if (cfg_val) shadow_d[cfg_cnt_q] = cfg_ker;
    cfg_cnt_d = cfg_cnt_q;
    if (commit)       cfg_cnt_d = '0;
    else if (cfg_val) cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
    // The final word lands in the shadow and the active bank on the same edge.
    active_d = commit ? shadow_d : active_q;
    cfg_done_d = cfg_done_q;
    if (commit)       cfg_done_d = 1'b1;
    else if (cfg_val) cfg_done_d = 1'b0;
    loaded_d = loaded_q | commit;
  end

  // Nothing launches as valid until a complete kernel has been committed since reset.
  assign img_c[0]       = up_img;
  assign img_val_c[0]   = up_val & loaded_q;
  assign acc_c[0]       = '0;
  assign acc_val_c[0]   = up_val & loaded_q;
  assign img_val_unused = img_val_c[TAPS];

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_tap #(
      .IMG_WIDTH(IMG_WIDTH),
      .KER_WIDTH(KER_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_tap (
      .clk       (clk),
      .rst       (rst),
      .flush     (commit),
      .ker       (active_q[k]),
      .img_i     (img_c[k]),
      .img_val_i (img_val_c[k]),
      .acc_i     (acc_c[k]),
      .acc_val_i (acc_val_c[k]),
      .img_o     (img_c[k+1]),
      .img_val_o (img_val_c[k+1]),
      .acc_o     (acc_c[k+1]),
      .acc_val_o (acc_val_c[k+1])
    );
  end

  always_comb begin
    dn_out_d = OUT_WIDTH'(rnd_sat_val(64'($signed(acc_c[TAPS])), SHIFT, OUT_WIDTH));
    dn_val_d = acc_val_c[TAPS] && !commit;
    dn_sat_d = dn_val_d && rnd_sat_clip(64'($signed(acc_c[TAPS])), SHIFT, OUT_WIDTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      active_q   <= '0;
      cfg_cnt_q  <= '0;
      cfg_done_q <= 1'b0;
      loaded_q   <= 1'b0;
      dn_out_q   <= '0;
      dn_val_q   <= 1'b0;
      dn_sat_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      cfg_cnt_q  <= cfg_cnt_d;
      cfg_done_q <= cfg_done_d;
      loaded_q   <= loaded_d;
      dn_out_q   <= dn_out_d;
      dn_val_q   <= dn_val_d;
      dn_sat_q   <= dn_sat_d;
    end
  end

  assign cfg_done = cfg_done_q;
  assign dn_img   = img_c[TAPS];
  assign dn_out   = dn_out_q;
  assign dn_val   = dn_val_q;
  assign dn_sat   = dn_sat_q;

endmodule

// File: tb/tb_multiply_add_chain.sv
// Directed bench for multiply_add_chain: SHIFT=0 and SHIFT=2 instances share stimulus;
// a window-sum scoreboard is filled as samples are driven and drained as results come due.
module tb_multiply_add_chain;

  localparam int T    = 4;
  localparam int LAT  = 4 * T + 1;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_ker, up_img;
  logic        cfg_val, up_val;
  logic        cfg_done, cfg_done_r, dn_val, dn_val_r, dn_sat, dn_sat_r;
  logic [15:0] dn_img, dn_img_r, dn_out, dn_out_r;

  always #5 clk = ~clk;

  multiply_add_chain #(.IMG_WIDTH(16), .KER_WIDTH(16), .TAPS(T), .OUT_WIDTH(16), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .cfg_ker(cfg_ker), .cfg_val(cfg_val), .cfg_done(cfg_done),
    .up_img(up_img), .up_val(up_val), .dn_img(dn_img), .dn_out(dn_out),
    .dn_val(dn_val), .dn_sat(dn_sat));

  multiply_add_chain #(.IMG_WIDTH(16), .KER_WIDTH(16), .TAPS(T), .OUT_WIDTH(16), .SHIFT(2)) dut_r (
    .clk(clk), .rst(rst), .cfg_ker(cfg_ker), .cfg_val(cfg_val), .cfg_done(cfg_done_r),
    .up_img(up_img), .up_val(up_val), .dn_img(dn_img_r), .dn_out(dn_out_r),
    .dn_val(dn_val_r), .dn_sat(dn_sat_r));

  typedef struct {
    int     t0;
    longint sum;
    bit     sv;
  } ent_t;

  logic [15:0] x_h  [MAXC];
  bit          v_h  [MAXC];
  bit          cm_h [MAXC];
  logic [15:0] kw_h [MAXC][T];
  logic [15:0] act_m [T];
  logic [15:0] shd_m [T];
  int          cnt_m;
  bit          done_m, loaded_m;
  int          cyc, base;
  ent_t        sb[$];
  int          ncomp, nfail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic longint rshift(input longint v, input int sh);
    if (sh == 0) return v;
    return (v + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  function automatic logic [15:0] sat16(input longint v, output bit clip);
    clip = 1'b0;
    if (v > 32767)  begin clip = 1'b1; return 16'h7fff; end
    if (v < -32768) begin clip = 1'b1; return 16'h8000; end
    return 16'(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < T; k++) begin
      act_m[k] = '0;
      shd_m[k] = '0;
    end
    cnt_m = 0; done_m = 1'b0; loaded_m = 1'b0;
    sb.delete();
    base = cyc;
  endtask

  task automatic check_outputs();
    ent_t        e;
    bit          ev, c0, c2;
    logic [15:0] r0, r2;
    chk("cfg_done", cfg_done, done_m);
    chk("cfg_done_r", cfg_done_r, done_m);
    if (cyc - 3 * T >= base) chk("dn_img", dn_img, x_h[cyc-3*T]);
    else                     chk("dn_img_flushed", dn_img, 0);
    if (sb.size() > 0 && sb[0].t0 + LAT == cyc) begin
      e  = sb.pop_front();
      ev = e.sv;
      for (int c = e.t0; c <= e.t0 + 4 * T; c++) if (cm_h[c]) ev = 1'b0;
      chk("dn_val", dn_val, ev);
      chk("dn_val_r", dn_val_r, ev);
      if (ev) begin
        r0 = sat16(e.sum, c0);
        r2 = sat16(rshift(e.sum, 2), c2);
        chk("dn_out", dn_out, r0);
        chk("dn_sat", dn_sat, c0);
        chk("dn_out_r", dn_out_r, r2);
        chk("dn_sat_r", dn_sat_r, c2);
      end else begin
        chk("dn_sat_inval", dn_sat, 0);
        chk("dn_sat_r_inval", dn_sat_r, 0);
      end
    end else begin
      chk("dn_val_idle", dn_val, 0);
      chk("dn_val_r_idle", dn_val_r, 0);
    end
  endtask

  task automatic step(input logic [15:0] img, input bit v, input bit cv, input logic [15:0] ck);
    ent_t e;
    bit   commit;
    up_img = img; up_val = v; cfg_val = cv; cfg_ker = ck;
    x_h[cyc] = img;
    v_h[cyc] = v && loaded_m;
    for (int k = 0; k < T; k++) kw_h[cyc][k] = act_m[k];
    commit = cv && (cnt_m == T - 1);
    cm_h[cyc] = commit;
    if (cv) begin
      shd_m[cnt_m] = ck;
      cnt_m  = commit ? 0 : cnt_m + 1;
      done_m = commit;
    end
    if (commit) begin
      for (int k = 0; k < T; k++) act_m[k] = shd_m[k];
      loaded_m = 1'b1;
    end
    if (cyc - (T - 1) >= base) begin
      e.t0 = cyc - (T - 1);
      e.sum = 0;
      e.sv = 1'b1;
      for (int k = 0; k < T; k++) begin
        e.sum += longint'($signed(kw_h[e.t0][k])) * longint'($signed(x_h[e.t0+k]));
        e.sv &= v_h[e.t0+k];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_dn_val", dn_val, 0);
    chk("arst_dn_out", dn_out, 0);
    chk("arst_dn_sat", dn_sat, 0);
    chk("arst_dn_img", dn_img, 0);
    chk("arst_cfg_done", cfg_done, 0);
    chk("arst_dn_val_r", dn_val_r, 0);
    chk("arst_dn_out_r", dn_out_r, 0);
    chk("arst_cfg_done_r", cfg_done_r, 0);
    up_val = 1'b0; cfg_val = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    ncomp = 0; nfail = 0; cyc = 0;
    rst = 1'b1; up_img = '0; up_val = 1'b0; cfg_val = 1'b0; cfg_ker = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dn_val", dn_val, 0);
    chk("rst_dn_out", dn_out, 0);
    chk("rst_dn_sat", dn_sat, 0);
    chk("rst_dn_img", dn_img, 0);
    chk("rst_cfg_done", cfg_done, 0);
    rst = 1'b0;

    // kernel {1,2,3,4}, then ramp 1..20 (windows 30, 40, ...), one gap, more ramp
    for (int k = 0; k < T; k++) step(16'h0, 1'b0, 1'b1, 16'(k + 1));
    for (int i = 0; i < 20; i++) step(16'(i + 1), 1'b1, 1'b0, 16'h0);
    step(16'd100, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) step(16'(i + 21), 1'b1, 1'b0, 16'h0);
    // negative ramp -1..-10 (SHIFT=2 instance rounds -30 to -7)
    for (int i = 0; i < 10; i++) step(16'(-(i + 1)), 1'b1, 1'b0, 16'h0);

    // mid-stream reload to all-0x7FFF: partial load keeps old kernel, final word commits
    step(16'd7, 1'b1, 1'b1, 16'h7fff);
    step(16'd8, 1'b1, 1'b1, 16'h7fff);
    for (int i = 0; i < 20; i++) step(16'(i + 9), 1'b1, 1'b0, 16'h0);
    step(16'h7fff, 1'b1, 1'b1, 16'h7fff);
    step(16'h7fff, 1'b1, 1'b1, 16'h7fff);
    for (int i = 0; i < 25; i++) step(16'h7fff, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 25; i++) step(16'h8000, 1'b1, 1'b0, 16'h0);

    // mixed-sign kernel loaded while random samples with occasional gaps stream in
    step(16'(-5), 1'b1, 1'b1, 16'd5);
    step(16'd6,   1'b1, 1'b1, 16'hfffd);
    step(16'd7,   1'b1, 1'b1, 16'd7);
    step(16'd8,   1'b1, 1'b1, 16'hfffe);
    for (int i = 0; i < 40; i++)
      step(16'($urandom_range(0, 65535)), ($urandom_range(0, 7) != 0), 1'b0, 16'h0);

    // asynchronous reset mid-stream; outputs stay invalid until a full reload
    for (int i = 0; i < 6; i++) step(16'(i + 50), 1'b1, 1'b0, 16'h0);
    async_reset();
    for (int i = 0; i < 25; i++) step(16'(i + 3), 1'b1, 1'b0, 16'h0);
    for (int k = 0; k < T; k++) step(16'(k + 1), 1'b1, 1'b1, 16'(k + 1));
    for (int i = 0; i < 30; i++) step(16'(i + 1), 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) step(16'h0, 1'b0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
